// File: rtl/md_sequencer.sv
// Multicycle unsigned multiply/divide sequencer. It borrows the shared al_unit
// for 32 shift-add / restoring-divide iterations and leaves the result in hi/lo.
module md_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] ALUC_ADD = 4'b0000,
  parameter logic [3:0] ALUC_SUB = 4'b0001
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] md_ra,
  output logic [WIDTH-1:0] md_rb,
  output logic [3:0]       md_aluc,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] b_reg;
  logic             op_reg;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] mul_sum;
  logic             mul_c;
  logic             div_ge;

  // Partial remainder shifted left by one; its lost top bit forces a subtract.
  always_comb begin
    sh      = {hi[WIDTH-2:0], lo[WIDTH-1]};
    mul_sum = lo[0] ? alu_result : hi;
    mul_c   = lo[0] & (alu_result < hi);
    div_ge  = hi[WIDTH-1] | (alu_result < sh);
  end

  always_comb begin
    md_ra   = '0;
    md_rb   = '0;
    md_aluc = ALUC_ADD;
    if (state == RUN) begin
      md_rb = b_reg;
      if (op_reg) begin
        md_ra   = sh;
        md_aluc = ALUC_SUB;
      end else begin
        md_ra = hi;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_reg <= op;
            dz     <= 1'b0;
            busy   <= 1'b1;
            if (!op) begin
              hi    <= '0;
              lo    <= src_b;
              b_reg <= src_a;
              count <= CW'(WIDTH - 1);
              state <= RUN;
            end else if (src_b != '0) begin
              hi    <= '0;
              lo    <= src_a;
              b_reg <= src_b;
              count <= CW'(WIDTH - 1);
              state <= RUN;
            end else begin
              hi    <= src_a;
              lo    <= '1;
              b_reg <= src_b;
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          count <= count - 1'b1;
          if (op_reg) begin
            hi <= div_ge ? alu_result : sh;
            lo <= {lo[WIDTH-2:0], div_ge};
          end else begin
            hi <= {mul_c, mul_sum[WIDTH-1:1]};
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          if (count == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed vector table, randomized ops
// against a plain-arithmetic model, and hand-written abort/ignore sequences.
module tb_md_sequencer;

  logic        clk;
  logic        clrn;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] md_ra;
  logic [31:0] md_rb;
  logic [3:0]  md_aluc;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int assert_n = 0;
  int fail_n   = 0;

  md_sequencer dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .md_ra(md_ra), .md_rb(md_rb), .md_aluc(md_aluc), .alu_result(alu_result),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  // Stand-in for the shared al_unit
  assign alu_result = (md_aluc == 4'b0001) ? md_ra - md_rb : md_ra + md_rb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_n++;
    if (act !== exp) begin
      fail_n++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic [63:0] p;
    edz = 1'b0;
    if (!o) begin
      p  = 64'(a) * 64'(b);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh  = a;
      el  = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      eh = a % b;
      el = a / b;
    end
  endfunction

  // Issues one op, scrambles the operand inputs while it runs, and watches a 40-cycle window
  task automatic apply_stimulus(input logic o, input logic [31:0] a, input logic [31:0] b,
                                input bit noisy, output int lat, output int busy_n, output int done_n);
    lat = -1;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) lat = i;
        if (noisy) start = 1'b1;
      end else if (noisy && (i == 5 || i == 20)) begin
        start = 1'b1;
      end
      op = 1'($urandom); src_a = $urandom; src_b = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                               input bit noisy, input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int lat, busy_n, done_n, exp_lat;
    apply_stimulus(o, a, b, noisy, lat, busy_n, done_n);
    exp_lat = edz ? 1 : 33;
    check_output({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_output({tag, " busy cycles"}, 64'(busy_n), 64'(exp_lat));
    check_output({tag, " done pulses"}, 64'(done_n), 64'd1);
    check_output({tag, " hi"}, 64'(hi), 64'(eh));
    check_output({tag, " lo"}, 64'(lo), 64'(el));
    check_output({tag, " dz"}, 64'(dz), 64'(edz));
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic        ro, edz;
    int          done_n;

    vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0};
    vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1};
    vecs[6] = '{1'b0, 32'd3,          32'd3,          32'd0,          32'd9,          1'b0};

    clrn = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    #12;
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset done", 64'(done), 64'd0);
    check_output("reset dz", 64'(dz), 64'd0);
    check_output("reset hi", 64'(hi), 64'd0);
    check_output("reset lo", 64'(lo), 64'd0);
    check_output("idle md_ra", 64'(md_ra), 64'd0);
    check_output("idle md_aluc", 64'(md_aluc), 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, 1'b0,
                    vecs[i].eh, vecs[i].el, vecs[i].edz);

    // Starts during RUN and in the DONE cycle must be dropped
    run_and_check("ignored starts", 1'b0, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ro = 1'($urandom);
      ra = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rb = (i % 5 == 0) ? 32'd0 : ((i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      ref_op(ro, ra, rb, eh, el, edz);
      run_and_check($sformatf("rand%0d", i), ro, ra, rb, 1'b0, eh, el, edz);
    end

    // Abort divu 100/7 around iteration 10 with a one-cycle reset pulse
    @(negedge clk);
    op = 1'b1; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_output("pre-abort busy", 64'(busy), 64'd1);
    clrn = 1'b0;
    #1;
    check_output("abort busy", 64'(busy), 64'd0);
    check_output("abort hi", 64'(hi), 64'd0);
    check_output("abort lo", 64'(lo), 64'd0);
    check_output("abort done", 64'(done), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check_output("abort no done", 64'(done_n), 64'd0);
    check_output("abort idle busy", 64'(busy), 64'd0);
    run_and_check("post-abort div", 1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_n, fail_n);
    $finish;
  end

endmodule
